instr_prefetch_8051: RTL and testbench

INSTR_PREFETCH_8051 -- requirements
Module: instr_prefetch_8051

---
 rtl/instr_prefetch_8051_if.sv | 32 +++
 rtl/instr_prefetch_8051.sv | 123 ++++++++++++
 tb/tb_instr_prefetch_8051.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_8051_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_8051_if
// Purpose  : Code-memory, redirect and decode-side signals of the 8051 prefetcher.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_prefetch_8051_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_instr;
    logic [1:0]  out_len;
    logic [15:0] out_pc;

    // Prefetcher side
    modport master (
        output mem_req, mem_addr, out_valid, out_instr, out_len, out_pc,
        input  mem_rvalid, mem_rdata, redirect, redirect_pc, out_ready
    );

    // Memory / core side
    modport slave (
        input  mem_req, mem_addr, out_valid, out_instr, out_len, out_pc,
        output mem_rvalid, mem_rdata, redirect, redirect_pc, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_prefetch_8051.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_8051
// Purpose  : Byte-wise code prefetch queue presenting whole 8051 instructions.
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch_8051 #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input wire logic              clk,
    input wire logic              rst,
    instr_prefetch_8051_if.master bus
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [15:0]        r_fetch_pc;
    logic [15:0]        r_head_pc;
    logic               r_outstanding;
    logic               r_drop;

    logic [7:0]         w_b0;
    logic [7:0]         w_b1;
    logic [7:0]         w_b2;
    logic [1:0]         w_len;
    logic               w_valid;
    logic               w_fire;
    logic               w_push;
    logic               w_req;
    logic [c_cnt_w-1:0] w_pop_cnt;

    assign w_b0 = r_mem[r_rd_ptr];
    assign w_b1 = r_mem[r_rd_ptr + c_ptr_w'(1)];
    assign w_b2 = r_mem[r_rd_ptr + c_ptr_w'(2)];

    always_comb begin
        w_len = 2'd1;
        case (w_b0)
            8'h75, 8'hB4:                      w_len = 2'd3;
            8'h74, 8'h25, 8'hF5, 8'h24, 8'h80: w_len = 2'd2;
            default:                           w_len = 2'd1;
        endcase
    end

    assign w_valid   = !bus.redirect && (r_count >= c_cnt_w'(w_len));
    assign w_fire    = w_valid && bus.out_ready;
    assign w_pop_cnt = w_fire ? c_cnt_w'(w_len) : '0;
    // A response tagged for dropping belongs to a fetch stream that was abandoned.
    assign w_push    = bus.mem_rvalid && r_outstanding && !r_drop && !bus.redirect;
    assign w_req     = !rst && !r_outstanding && !bus.redirect && (r_count < c_depth);

    assign bus.mem_req   = w_req;
    assign bus.mem_addr  = r_fetch_pc;
    assign bus.out_valid = w_valid;
    assign bus.out_pc    = r_head_pc;

    always_comb begin
        bus.out_instr = 24'h000000;
        bus.out_len   = 2'd0;
        if (w_valid) begin
            bus.out_len = w_len;
            case (w_len)
                2'd3:    bus.out_instr = {w_b0, w_b1, w_b2};
                2'd2:    bus.out_instr = {w_b0, w_b1, 8'h00};
                default: bus.out_instr = {w_b0, 16'h0000};
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_fetch_pc    <= RESET_PC;
            r_head_pc     <= RESET_PC;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else if (bus.redirect) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= bus.redirect_pc;
            r_head_pc  <= bus.redirect_pc;
            // Keep the request slot busy until the stale byte has come back.
            if (r_outstanding && !bus.mem_rvalid) begin
                r_drop <= 1'b1;
            end else begin
                r_outstanding <= 1'b0;
                r_drop        <= 1'b0;
            end
        end else begin
            if (w_req) begin
                r_outstanding <= 1'b1;
                r_fetch_pc    <= r_fetch_pc + 16'd1;
            end else if (bus.mem_rvalid && r_outstanding) begin
                r_outstanding <= 1'b0;
                r_drop        <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_fire) begin
                r_rd_ptr  <= r_rd_ptr + c_ptr_w'(w_len);
                r_head_pc <= r_head_pc + 16'(w_len);
            end
            r_count <= r_count + c_cnt_w'(w_push) - w_pop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.mem_rdata;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_8051.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_prefetch_8051
// Purpose  : Self-checking bench: byte-queue reference model, memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_8051;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_prefetch_8051_if bus();

    instr_prefetch_8051 #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [23:0] instr;
        logic [1:0]  len;
    } fire_t;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [1:0]  len;
        logic [23:0] instr;
    } vec_t;

    logic [7:0]  img [65536];
    logic [7:0]  q [$];
    fire_t       fires [$];
    logic [15:0] m_head, m_fetch, pend_addr;
    logic        pend, drop;
    int          pend_lat;
    int          lat_min, lat_max;
    logic        tb_ready, tb_redirect;
    logic [15:0] tb_rpc;
    int          checks = 0;
    int          failures = 0;

    logic        s_valid, s_req;
    logic [15:0] s_addr, s_pc;
    logic [23:0] s_instr;
    logic [1:0]  s_len;
    int          s_qsize;

    function automatic logic [1:0] ref_len(input logic [7:0] op);
        case (op)
            8'h75, 8'hB4:                      return 2'd3;
            8'h74, 8'h25, 8'hF5, 8'h24, 8'h80: return 2'd2;
            default:                           return 2'd1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the queue model, advance the model.
    task automatic step();
        logic        deliver, exp_valid, exp_req, fire;
        logic [1:0]  elen;
        logic [23:0] einstr;
        deliver = pend && (pend_lat <= 1);
        bus.mem_rvalid  = deliver;
        bus.mem_rdata   = deliver ? img[pend_addr] : 8'($urandom);
        bus.redirect    = tb_redirect;
        bus.redirect_pc = tb_rpc;
        bus.out_ready   = tb_ready;
        #1;
        s_valid = bus.out_valid; s_req = bus.mem_req; s_addr = bus.mem_addr;
        s_instr = bus.out_instr; s_len = bus.out_len; s_pc = bus.out_pc;
        s_qsize = q.size();

        exp_valid = 1'b0;
        elen      = 2'd0;
        einstr    = 24'h0;
        if (!tb_redirect && q.size() > 0) begin
            elen      = ref_len(q[0]);
            exp_valid = (q.size() >= int'(elen));
        end
        chk("out_valid", 32'(s_valid), 32'(exp_valid));
        if (exp_valid) begin
            einstr[23:16] = q[0];
            if (elen >= 2'd2) einstr[15:8] = q[1];
            if (elen == 2'd3) einstr[7:0]  = q[2];
            chk("out_instr", 32'(s_instr), 32'(einstr));
            chk("out_len", 32'(s_len), 32'(elen));
            chk("out_pc", 32'(s_pc), 32'(m_head));
        end
        exp_req = !pend && !tb_redirect && (q.size() < DEPTH);
        chk("mem_req", 32'(s_req), 32'(exp_req));
        if (exp_req) chk("mem_addr", 32'(s_addr), 32'(m_fetch));

        fire = exp_valid && tb_ready;
        if (fire) fires.push_back('{s_pc, s_instr, s_len});

        if (tb_redirect) begin
            q.delete();
            m_head  = tb_rpc;
            m_fetch = tb_rpc;
            if (pend && !deliver) drop = 1'b1;
        end else if (fire) begin
            for (int k = 0; k < int'(elen); k++) void'(q.pop_front());
            m_head = m_head + 16'(elen);
        end
        if (deliver) begin
            if (!tb_redirect && !drop) q.push_back(img[pend_addr]);
            pend = 1'b0;
            drop = 1'b0;
        end else if (pend) begin
            pend_lat--;
        end
        if (exp_req) begin
            pend      = 1'b1;
            pend_addr = m_fetch;
            pend_lat  = int'($urandom_range(lat_max, lat_min));
            m_fetch   = m_fetch + 16'd1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input logic late_rsp);
        rst = 1'b1;
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mem_rvalid = late_rsp && pend && (i == 1);
            bus.mem_rdata  = 8'hA5;
            #1;
            chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
            chk("rst_mem_addr", 32'(bus.mem_addr), 32'(RST_PC));
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_instr", 32'(bus.out_instr), 32'd0);
            chk("rst_out_len", 32'(bus.out_len), 32'd0);
            chk("rst_out_pc", 32'(bus.out_pc), 32'(RST_PC));
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
        q.delete();
        fires.delete();
        pend    = 1'b0;
        drop    = 1'b0;
        m_fetch = RST_PC;
        m_head  = RST_PC;
        rst     = 1'b0;
    endtask

    task automatic run_fires(input int n, input int budget);
        for (int c = 0; c < budget && fires.size() < n; c++) step();
        chk("fire_timeout", 32'(fires.size() >= n), 32'd1);
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        tb_redirect = 1'b1;
        tb_rpc      = pc;
        step();
        tb_redirect = 1'b0;
        fires.delete();
    endtask

    task automatic chk_fire(input string name, input int idx, input logic [15:0] pc,
                            input logic [23:0] instr, input logic [1:0] len);
        if (fires.size() > idx) begin
            chk({name, "_pc"}, 32'(fires[idx].pc), 32'(pc));
            chk({name, "_instr"}, 32'(fires[idx].instr), 32'(instr));
            chk({name, "_len"}, 32'(fires[idx].len), 32'(len));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [12];
        logic [15:0] a;
        logic        have, seen;
        logic [23:0] h_instr;
        logic [15:0] h_pc;
        logic [1:0]  h_len;

        vecs[0]  = '{8'h75, 8'h12, 8'h34, 2'd3, 24'h751234};
        vecs[1]  = '{8'hB4, 8'h56, 8'h78, 2'd3, 24'hB45678};
        vecs[2]  = '{8'h74, 8'h9A, 8'hBC, 2'd2, 24'h749A00};
        vecs[3]  = '{8'h25, 8'h11, 8'h22, 2'd2, 24'h251100};
        vecs[4]  = '{8'hF5, 8'h33, 8'h44, 2'd2, 24'hF53300};
        vecs[5]  = '{8'h24, 8'h55, 8'h66, 2'd2, 24'h245500};
        vecs[6]  = '{8'h80, 8'hFE, 8'h01, 2'd2, 24'h80FE00};
        vecs[7]  = '{8'h00, 8'h75, 8'hB4, 2'd1, 24'h000000};
        vecs[8]  = '{8'h73, 8'hAA, 8'hBB, 2'd1, 24'h730000};
        vecs[9]  = '{8'hFF, 8'h01, 8'h02, 2'd1, 24'hFF0000};
        vecs[10] = '{8'h76, 8'h74, 8'h75, 2'd1, 24'h760000};
        vecs[11] = '{8'hB5, 8'h12, 8'h13, 2'd1, 24'hB50000};

        for (int i = 0; i < 65536; i++) img[i] = 8'($urandom);
        img[0] = 8'h74; img[1] = 8'h05; img[2] = 8'h75; img[3] = 8'h30; img[4] = 8'h03;

        tb_ready = 1'b1; tb_redirect = 1'b0; tb_rpc = 16'h0;
        lat_min = 1; lat_max = 1;
        pend = 1'b0; drop = 1'b0; pend_lat = 0; pend_addr = 16'h0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 8'h00; bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0; bus.out_ready = 1'b0;
        @(negedge clk);
        do_reset(1'b0);

        // First two instructions straight out of reset
        step();
        chk("first_req", 32'(s_req), 32'd1);
        chk("first_addr", 32'(s_addr), 32'(RST_PC));
        run_fires(2, 40);
        chk_fire("boot0", 0, 16'h0000, 24'h740500, 2'd2);
        chk_fire("boot1", 1, 16'h0002, 24'h753003, 2'd3);

        // Decode stage stalls for ten cycles
        tb_ready = 1'b0;
        have = 1'b0;
        h_instr = '0; h_pc = '0; h_len = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_valid) begin
                if (have) begin
                    chk("stall_instr", 32'(s_instr), 32'(h_instr));
                    chk("stall_pc", 32'(s_pc), 32'(h_pc));
                    chk("stall_len", 32'(s_len), 32'(h_len));
                end
                have = 1'b1;
                h_instr = s_instr; h_pc = s_pc; h_len = s_len;
            end
        end
        chk("stall_full_req", 32'(s_req), 32'd0);
        chk("stall_valid", 32'(s_valid), 32'd1);
        tb_ready = 1'b1;
        fires.delete();
        run_fires(4, 40);

        // Length-decode table
        for (int i = 0; i < 12; i++) begin
            a = 16'h2000 + 16'(i * 8);
            img[a] = vecs[i].op; img[a + 16'd1] = vecs[i].b1; img[a + 16'd2] = vecs[i].b2;
            redirect_to(a);
            run_fires(1, 30);
            chk_fire($sformatf("vec%0d", i), 0, a, vecs[i].instr, vecs[i].len);
        end

        // Redirect while the request to 0005h is in flight
        img[5] = 8'h75; img[6] = 8'h11;
        img[7] = 8'hB4; img[8] = 8'h08; img[9] = 8'h03;
        lat_min = 2; lat_max = 2;
        for (int c = 0; c < 20 && pend; c++) step();
        redirect_to(16'h0005);
        step();
        chk("r35_req", 32'(s_req), 32'd1);
        chk("r35_addr", 32'(s_addr), 32'h0005);
        redirect_to(16'h0007);
        run_fires(1, 30);
        chk_fire("r35", 0, 16'h0007, 24'hB40803, 2'd3);

        // Three-byte opcode must wait for its last byte
        lat_min = 3; lat_max = 3;
        img[16'h3000] = 8'h75; img[16'h3001] = 8'h11; img[16'h3002] = 8'h22;
        redirect_to(16'h3000);
        seen = 1'b0;
        for (int c = 0; c < 40 && fires.size() == 0; c++) begin
            step();
            if (s_qsize == 2 && !seen) begin
                chk("r36_partial_valid", 32'(s_valid), 32'd0);
                seen = 1'b1;
            end
        end
        chk("r36_timeout", 32'(fires.size() >= 1), 32'd1);
        chk_fire("r36", 0, 16'h3000, 24'h751122, 2'd3);

        // Address wrap FFFFh -> 0000h
        lat_min = 1; lat_max = 1;
        img[16'hFFFF] = 8'h00; img[0] = 8'h24; img[1] = 8'h02;
        redirect_to(16'hFFFF);
        run_fires(2, 30);
        chk_fire("wrap0", 0, 16'hFFFF, 24'h000000, 2'd1);
        chk_fire("wrap1", 1, 16'h0000, 24'h240200, 2'd2);

        // Randomised traffic
        lat_min = 1; lat_max = 4;
        for (int c = 0; c < 3000; c++) begin
            tb_ready    = ($urandom_range(0, 3) != 0);
            tb_redirect = ($urandom_range(0, 29) == 0);
            tb_rpc      = 16'($urandom);
            step();
        end
        tb_redirect = 1'b0;
        tb_ready    = 1'b1;

        // Reset with a request in flight; its response arrives during reset
        lat_min = 3; lat_max = 3;
        for (int c = 0; c < 10 && !pend; c++) step();
        do_reset(1'b1);
        step();
        chk("r38_req", 32'(s_req), 32'd1);
        chk("r38_addr", 32'(s_addr), 32'(RST_PC));
        run_fires(1, 30);
        chk_fire("r38", 0, RST_PC, 24'h240200, 2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
